// File: rtl/dds_chirp_nco.sv
// Quadrature NCO with a linear-FM sweep engine (tone, one-shot, repeating and triangle chirp).
// A 3-stage pipeline folds a quarter-wave sine table into signed sin/cos samples.
module dds_chirp_nco #(
    parameter int PHASE_W  = 32,
    parameter int LUT_AW   = 10,
    parameter int OUT_W    = 16,
    parameter int LEN_W    = 20,
    parameter     LUT_FILE = "sin_qtr.hex"
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [1:0]                cfg_mode,
    input  logic [PHASE_W-1:0]        cfg_ftw,
    input  logic [PHASE_W-1:0]        cfg_rate,
    input  logic [LEN_W-1:0]          cfg_len,
    input  logic [PHASE_W-1:0]        cfg_phase_ofs,
    input  logic                      start,
    input  logic                      stop,
    output logic                      busy,
    output logic                      sweep_done,
    output logic                      dout_valid,
    output logic signed [OUT_W-1:0]   dout_sin,
    output logic signed [OUT_W-1:0]   dout_cos
);

    localparam int LUT_N  = 1 << LUT_AW;
    localparam int TOP_SH = PHASE_W - LUT_AW - 2;

    typedef enum logic [1:0] {S_IDLE, S_TONE, S_UP, S_DOWN} state_t;

    // The table is built at elaboration from the same formula that generates LUT_FILE;
    // the half-sample offset keeps every entry below full scale so negation is safe.
    function automatic logic [OUT_W-1:0] qtr_sine(input int k);
        real amp;
        real ang;
        amp = real'((1 << (OUT_W - 1)) - 1);
        ang = 3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / real'(LUT_N);
        return OUT_W'($rtoi(amp * $sin(ang) + 0.5));
    endfunction

    function automatic logic signed [OUT_W-1:0] apply_sign(input logic signed [OUT_W-1:0] v,
                                                           input logic neg);
        return neg ? -v : v;
    endfunction

    logic [OUT_W-1:0] lut_rom [LUT_N];
    for (genvar k = 0; k < LUT_N; k++) begin : g_lut
        assign lut_rom[k] = qtr_sine(k);
    end

    state_t             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d, ftw_q, ftw_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [1:0]         sh_mode_q, sh_mode_d;
    logic [PHASE_W-1:0] sh_ftw_q, sh_ftw_d, sh_rate_q, sh_rate_d, sh_ofs_q, sh_ofs_d;
    logic [LEN_W-1:0]   sh_len_q, sh_len_d;

    logic [LEN_W-1:0]   last_cnt;
    logic               leg_end;
    logic               active;

    assign active    = (state_q != S_IDLE);
    assign busy      = active;
    assign cfg_ready = (state_q == S_IDLE);
    assign last_cnt  = (sh_len_q == '0) ? '0 : sh_len_q - LEN_W'(1);
    assign leg_end   = (cnt_q == last_cnt);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        ftw_d     = ftw_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        sh_mode_d = sh_mode_q;
        sh_ftw_d  = sh_ftw_q;
        sh_rate_d = sh_rate_q;
        sh_len_d  = sh_len_q;
        sh_ofs_d  = sh_ofs_q;

        if (cfg_valid && cfg_ready) begin
            sh_mode_d = cfg_mode;
            sh_ftw_d  = cfg_ftw;
            sh_rate_d = cfg_rate;
            sh_len_d  = cfg_len;
            sh_ofs_d  = cfg_phase_ofs;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    phase_d = '0;
                    ftw_d   = sh_ftw_q;
                    cnt_d   = '0;
                    state_d = (sh_mode_q == 2'd0) ? S_TONE : S_UP;
                end
            end
            S_TONE: begin
                phase_d = phase_q + ftw_q;
                if (stop) state_d = S_IDLE;
            end
            S_UP: begin
                phase_d = phase_q + ftw_q;
                ftw_d   = ftw_q + sh_rate_q;
                cnt_d   = cnt_q + LEN_W'(1);
                if (stop) begin
                    state_d = S_IDLE;
                end else if (leg_end) begin
                    done_d = 1'b1;
                    cnt_d  = '0;
                    unique case (sh_mode_q)
                        2'd2:    ftw_d   = sh_ftw_q;
                        2'd3:    state_d = S_DOWN;
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_DOWN: begin
                phase_d = phase_q + ftw_q;
                ftw_d   = ftw_q - sh_rate_q;
                cnt_d   = cnt_q + LEN_W'(1);
                if (stop) begin
                    state_d = S_IDLE;
                end else if (leg_end) begin
                    cnt_d   = '0;
                    state_d = S_UP;
                end
            end
        endcase
    end

    // Stage 1: offset phase, split into quadrant and folded table addresses
    logic [LUT_AW+1:0]  top_bits;
    logic [1:0]         quad;
    logic [LUT_AW-1:0]  addr;
    logic [1:0]         q_p1_q, q_p1_d, q_p2_q;
    logic [LUT_AW-1:0]  sin_addr_p1_q, sin_addr_p1_d, cos_addr_p1_q, cos_addr_p1_d;
    logic               vld_p1_q, vld_p2_q, vld_p3_q;

    always_comb begin
        top_bits      = (LUT_AW + 2)'((phase_q + sh_ofs_q) >> TOP_SH);
        quad          = top_bits[LUT_AW+1:LUT_AW];
        addr          = top_bits[LUT_AW-1:0];
        q_p1_d        = quad;
        sin_addr_p1_d = quad[0] ? ~addr : addr;
        cos_addr_p1_d = quad[0] ? addr : ~addr;
    end

    // Stage 2: dual table read
    logic [OUT_W-1:0] sin_raw_p2_q, sin_raw_p2_d, cos_raw_p2_q, cos_raw_p2_d;
    assign sin_raw_p2_d = lut_rom[sin_addr_p1_q];
    assign cos_raw_p2_d = lut_rom[cos_addr_p1_q];

    // Stage 3: quadrant sign restore, outputs forced to zero when not valid
    logic signed [OUT_W-1:0] sin_p3_q, sin_p3_d, cos_p3_q, cos_p3_d;
    assign sin_p3_d = vld_p2_q ? apply_sign(sin_raw_p2_q, q_p2_q[1]) : '0;
    assign cos_p3_d = vld_p2_q ? apply_sign(cos_raw_p2_q, q_p2_q[1] ^ q_p2_q[0]) : '0;

    assign sweep_done = done_q;
    assign dout_valid = vld_p3_q;
    assign dout_sin   = sin_p3_q;
    assign dout_cos   = cos_p3_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q       <= S_IDLE;
            phase_q       <= '0;
            ftw_q         <= '0;
            cnt_q         <= '0;
            done_q        <= 1'b0;
            sh_mode_q     <= '0;
            sh_ftw_q      <= '0;
            sh_rate_q     <= '0;
            sh_len_q      <= '0;
            sh_ofs_q      <= '0;
            q_p1_q        <= '0;
            sin_addr_p1_q <= '0;
            cos_addr_p1_q <= '0;
            vld_p1_q      <= 1'b0;
            q_p2_q        <= '0;
            sin_raw_p2_q  <= '0;
            cos_raw_p2_q  <= '0;
            vld_p2_q      <= 1'b0;
            sin_p3_q      <= '0;
            cos_p3_q      <= '0;
            vld_p3_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            ftw_q         <= ftw_d;
            cnt_q         <= cnt_d;
            done_q        <= done_d;
            sh_mode_q     <= sh_mode_d;
            sh_ftw_q      <= sh_ftw_d;
            sh_rate_q     <= sh_rate_d;
            sh_len_q      <= sh_len_d;
            sh_ofs_q      <= sh_ofs_d;
            q_p1_q        <= q_p1_d;
            sin_addr_p1_q <= sin_addr_p1_d;
            cos_addr_p1_q <= cos_addr_p1_d;
            vld_p1_q      <= active;
            q_p2_q        <= q_p1_q;
            sin_raw_p2_q  <= sin_raw_p2_d;
            cos_raw_p2_q  <= cos_raw_p2_d;
            vld_p2_q      <= vld_p1_q;
            sin_p3_q      <= sin_p3_d;
            cos_p3_q      <= cos_p3_d;
            vld_p3_q      <= vld_p2_q;
        end
    end

endmodule

// File: tb/tb_dds_chirp_nco.sv
// Directed bench for dds_chirp_nco: table of tone/one-shot vectors plus hand-written
// sequences for triangle, repeating chirp, config blocking, start/stop and async reset.
module tb_dds_chirp_nco;

    localparam int PHASE_W = 32;
    localparam int LUT_AW  = 10;
    localparam int OUT_W   = 16;
    localparam int LEN_W   = 20;

    logic                     sys_clk = 1'b0;
    logic                     sys_rst;
    logic                     cfg_valid;
    logic                     cfg_ready;
    logic [1:0]               cfg_mode;
    logic [PHASE_W-1:0]       cfg_ftw;
    logic [PHASE_W-1:0]       cfg_rate;
    logic [LEN_W-1:0]         cfg_len;
    logic [PHASE_W-1:0]       cfg_phase_ofs;
    logic                     start;
    logic                     stop;
    logic                     busy;
    logic                     sweep_done;
    logic                     dout_valid;
    logic signed [OUT_W-1:0]  dout_sin;
    logic signed [OUT_W-1:0]  dout_cos;

    dds_chirp_nco #(
        .PHASE_W (PHASE_W),
        .LUT_AW  (LUT_AW),
        .OUT_W   (OUT_W),
        .LEN_W   (LEN_W)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_mode      (cfg_mode),
        .cfg_ftw       (cfg_ftw),
        .cfg_rate      (cfg_rate),
        .cfg_len       (cfg_len),
        .cfg_phase_ofs (cfg_phase_ofs),
        .start         (start),
        .stop          (stop),
        .busy          (busy),
        .sweep_done    (sweep_done),
        .dout_valid    (dout_valid),
        .dout_sin      (dout_sin),
        .dout_cos      (dout_cos)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [1:0]          mode;
        logic [31:0]         ftw;
        logic [31:0]         rate;
        logic [19:0]         len;
        logic [31:0]         ofs;
        logic [7:0]          nsamp;
        logic [3:0][15:0]    es;
        logic [3:0][15:0]    ec;
    } vec_t;

    function automatic logic [3:0][15:0] mk4(input int a, input int b, input int c, input int d);
        logic [3:0][15:0] r;
        r[0] = 16'(a);
        r[1] = 16'(b);
        r[2] = 16'(c);
        r[3] = 16'(d);
        return r;
    endfunction

    task automatic configure(input logic [1:0] m, input logic [31:0] f, input logic [31:0] r,
                             input logic [19:0] l, input logic [31:0] o);
        @(negedge sys_clk);
        cfg_mode      = m;
        cfg_ftw       = f;
        cfg_rate      = r;
        cfg_len       = l;
        cfg_phase_ofs = o;
        cfg_valid     = 1'b1;
        chk("cfg_ready_idle", longint'(cfg_ready), 1);
        @(negedge sys_clk);
        cfg_valid = 1'b0;
    endtask

    // Pulses start for one edge (E0); returns at the negedge after E0.
    task automatic kick();
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    task automatic stop_and_drain();
        stop = 1'b1;
        @(negedge sys_clk);
        stop = 1'b0;
        repeat (4) @(negedge sys_clk);
    endtask

    vec_t vt [6];

    initial begin
        int got, busyc, dones, trail;
        logic [31:0] tri_ftw [6];
        vec_t v;

        vt[0] = '{mode: 2'd0, ftw: 32'h4000_0000, rate: 32'd0, len: 20'd0, ofs: 32'd0, nsamp: 8'd4,
                  es: mk4(25, 32767, -25, -32767), ec: mk4(32767, -25, -32767, 25)};
        vt[1] = '{mode: 2'd0, ftw: 32'h4000_0000, rate: 32'd0, len: 20'd0, ofs: 32'h4000_0000, nsamp: 8'd4,
                  es: mk4(32767, -25, -32767, 25), ec: mk4(-25, -32767, 25, 32767)};
        vt[2] = '{mode: 2'd0, ftw: 32'h8000_0000, rate: 32'd0, len: 20'd0, ofs: 32'd0, nsamp: 8'd4,
                  es: mk4(25, -25, 25, -25), ec: mk4(32767, -32767, 32767, -32767)};
        vt[3] = '{mode: 2'd1, ftw: 32'd0, rate: 32'd1000, len: 20'd4, ofs: 32'd0, nsamp: 8'd4,
                  es: mk4(25, 25, 25, 25), ec: mk4(32767, 32767, 32767, 32767)};
        vt[4] = '{mode: 2'd1, ftw: 32'h4000_0000, rate: 32'd0, len: 20'd0, ofs: 32'd0, nsamp: 8'd1,
                  es: mk4(25, 0, 0, 0), ec: mk4(32767, 0, 0, 0)};
        vt[5] = '{mode: 2'd1, ftw: 32'h4000_0000, rate: 32'hC000_0000, len: 20'd3, ofs: 32'd0, nsamp: 8'd3,
                  es: mk4(25, 32767, 32767, 0), ec: mk4(32767, -25, -25, 0)};
        tri_ftw = '{32'd0, 32'd10, 32'd20, 32'd30, 32'd20, 32'd10};

        sys_rst = 1'b1;
        cfg_valid = 1'b0;
        cfg_mode = '0;
        cfg_ftw = '0;
        cfg_rate = '0;
        cfg_len = '0;
        cfg_phase_ofs = '0;
        start = 1'b0;
        stop = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("rst_cfg_ready", longint'(cfg_ready), 1);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(sweep_done), 0);
        chk("rst_valid", longint'(dout_valid), 0);
        chk("rst_sin", longint'(dout_sin), 0);
        chk("rst_cos", longint'(dout_cos), 0);
        sys_rst = 1'b0;
        @(negedge sys_clk);

        for (int n = 0; n < 6; n++) begin
            v = vt[n];
            configure(v.mode, v.ftw, v.rate, v.len, v.ofs);
            kick();
            got = 0;
            busyc = 0;
            dones = 0;
            if (v.mode == 2'd0) begin
                for (int c = 0; c < 20 && got < int'(v.nsamp); c++) begin
                    if (sweep_done) dones++;
                    if (dout_valid) begin
                        chk($sformatf("v%0d_sin%0d", n, got), longint'(dout_sin), longint'($signed(v.es[got])));
                        chk($sformatf("v%0d_cos%0d", n, got), longint'(dout_cos), longint'($signed(v.ec[got])));
                        got++;
                    end
                    if (got < int'(v.nsamp)) @(negedge sys_clk);
                end
                chk($sformatf("v%0d_nsamp", n), got, longint'(v.nsamp));
                stop = 1'b1;
                @(negedge sys_clk);
                stop = 1'b0;
                chk($sformatf("v%0d_busy_after_stop", n), longint'(busy), 0);
                trail = 0;
                for (int k = 0; k < 6; k++) begin
                    if (dout_valid) trail++;
                    if (sweep_done) dones++;
                    @(negedge sys_clk);
                end
                chk($sformatf("v%0d_trailing", n), trail, 3);
                chk($sformatf("v%0d_drained_sin", n), longint'(dout_sin), 0);
                chk($sformatf("v%0d_drained_cos", n), longint'(dout_cos), 0);
                chk($sformatf("v%0d_tone_dones", n), dones, 0);
            end else begin
                for (int k = 0; k < 20; k++) begin
                    if (busy) busyc++;
                    if (sweep_done) begin
                        dones++;
                        chk($sformatf("v%0d_done_busy_low", n), longint'(busy), 0);
                    end
                    if (dout_valid) begin
                        if (got < 4) begin
                            chk($sformatf("v%0d_sin%0d", n, got), longint'(dout_sin), longint'($signed(v.es[got])));
                            chk($sformatf("v%0d_cos%0d", n, got), longint'(dout_cos), longint'($signed(v.ec[got])));
                        end
                        got++;
                    end
                    @(negedge sys_clk);
                end
                chk($sformatf("v%0d_nsamp", n), got, longint'(v.nsamp));
                chk($sformatf("v%0d_busy_cycles", n), busyc, longint'(v.nsamp));
                chk($sformatf("v%0d_dones", n), dones, 1);
            end
        end

        // Triangle sweep; a config write attempted mid-run must be refused.
        configure(2'd3, 32'd0, 32'd10, 20'd3, 32'd0);
        kick();
        for (int i = 0; i < 18; i++) begin
            if (i < 8) chk($sformatf("tri_ftw%0d", i), longint'(dut.ftw_q), longint'(tri_ftw[i % 6]));
            chk($sformatf("tri_done%0d", i), longint'(sweep_done), (i % 6 == 3) ? 1 : 0);
            cfg_valid = 1'b0;
            if (i == 5) begin
                chk("cfg_ready_busy", longint'(cfg_ready), 0);
                cfg_mode  = 2'd0;
                cfg_ftw   = 32'd123;
                cfg_valid = 1'b1;
            end
            @(negedge sys_clk);
        end
        cfg_valid = 1'b0;
        stop_and_drain();
        kick();
        for (int i = 0; i < 5; i++) begin
            if (i == 1) chk("shadow_kept_ftw", longint'(dut.ftw_q), 10);
            if (i == 3) chk("shadow_kept_mode", longint'(sweep_done), 1);
            @(negedge sys_clk);
        end
        stop_and_drain();

        // Simultaneous start and stop in IDLE.
        start = 1'b1;
        stop  = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        stop  = 1'b0;
        chk("startstop_busy", longint'(busy), 0);
        trail = 0;
        for (int k = 0; k < 5; k++) begin
            if (dout_valid) trail++;
            @(negedge sys_clk);
        end
        chk("startstop_valid", trail, 0);

        // Repeating chirp, then asynchronous reset in the middle of it.
        configure(2'd2, 32'd0, 32'd1000, 20'd2, 32'd0);
        kick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rep_ftw%0d", i), longint'(dut.ftw_q), (i % 2 == 1) ? 1000 : 0);
            chk($sformatf("rep_done%0d", i), longint'(sweep_done), (i > 0 && i % 2 == 0) ? 1 : 0);
            @(negedge sys_clk);
        end
        chk("rep_valid_before_rst", longint'(dout_valid), 1);
        #2 sys_rst = 1'b1;
        #1;
        chk("arst_valid", longint'(dout_valid), 0);
        chk("arst_sin", longint'(dout_sin), 0);
        chk("arst_cos", longint'(dout_cos), 0);
        chk("arst_busy", longint'(busy), 0);
        chk("arst_done", longint'(sweep_done), 0);
        chk("arst_cfg_ready", longint'(cfg_ready), 1);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        kick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("restart_valid%0d", i), longint'(dout_valid), (i == 3) ? 1 : 0);
            chk($sformatf("restart_done%0d", i), longint'(sweep_done), 0);
            if (i == 3) begin
                chk("restart_sin", longint'(dout_sin), 25);
                chk("restart_cos", longint'(dout_cos), 32767);
            end
            @(negedge sys_clk);
        end
        stop_and_drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/dds_chirp_nco.md
Name: dds_chirp_nco

Overview:
Parametrised quadrature NCO with a built-in linear-FM (chirp) sweep engine for radar waveform generation. A phase accumulator drives an internal quarter-wave sine LUT with quadrant folding, producing signed sin/cos samples. Supported modes are single tone, one-shot up-chirp, repeating up-chirp and triangle chirp. It sits between the host/config logic and the DAC datapath.

Parameters:
PHASE_W, 32, phase accumulator and tuning-word width (bits).
LUT_AW, 10, quarter-wave LUT address width (2^LUT_AW entries).
OUT_W, 16, signed output sample width.
LEN_W, 20, sweep length counter width.
LUT_FILE, "sin_qtr.hex", LUT init file; entry k = round((2^(OUT_W-1)-1)*sin(pi/2*(k+0.5)/2^LUT_AW)).

Ports:
sys_clk  in  1  clock
sys_rst  in  1  asynchronous active-high reset
cfg_valid  in  1  config write request
cfg_ready  out  1  high only in IDLE; config accepted on cfg_valid&&cfg_ready
cfg_mode  in  2  0 tone, 1 one-shot chirp, 2 repeating chirp, 3 triangle
cfg_ftw  in  PHASE_W  start frequency tuning word
cfg_rate  in  PHASE_W  signed per-sample FTW increment
cfg_len  in  LEN_W  samples per sweep leg (0 treated as 1)
cfg_phase_ofs  in  PHASE_W  constant phase offset added before lookup
start  in  1  begin generation (IDLE only, ignored elsewhere)
stop  in  1  abort to IDLE
busy  out  1  state != IDLE
sweep_done  out  1  1-cycle pulse at end of each up-leg (modes 1-3)
dout_valid  out  1  sample valid
dout_sin  out  OUT_W  signed sine
dout_cos  out  OUT_W  signed cosine

Behaviour:
- Reset: state IDLE; phase_acc, ftw, cnt, shadow config, pipeline all 0; busy=0, sweep_done=0, dout_valid=0, dout_sin=dout_cos=0, cfg_ready=1. Reset mid-sweep aborts immediately, no done pulse.
- Config: on cfg_valid&&cfg_ready all cfg_* are latched into shadow registers; cfg_valid outside IDLE is not accepted (cfg_ready=0) and is not queued.
- FSM states: IDLE, TONE, UP, DOWN.
- IDLE: start at edge E0 (stop low) -> phase_acc<=0, ftw<=shadow ftw, cnt<=0; next state TONE (mode 0) else UP.
- Every active cycle: phase_acc<=phase_acc+ftw (modulo 2^PHASE_W). In UP ftw<=ftw+rate, in DOWN ftw<=ftw-rate (modulo, no saturation). cnt<=cnt+1 in UP/DOWN.
- UP at cnt==len-1: mode 1 -> IDLE with sweep_done. Mode 2 -> ftw<=shadow ftw, cnt<=0, stay UP, sweep_done. Mode 3 -> DOWN, cnt<=0, ftw continues, sweep_done.
- DOWN at cnt==len-1: -> UP, cnt<=0, no pulse.
- TONE runs until stop.
- stop has priority over start and over leg-end; -> IDLE next edge, no sweep_done. Samples already in the pipeline drain with dout_valid.
- Pipeline, 3 stages from the phase register:
  - S1: p=phase_acc+phase_ofs. Quadrant q=p[MSB:MSB-1]; address a=p[PHASE_W-3 -: LUT_AW]. sin address = a, or ~a for q odd. cos address = the complement of that choice (cos = sin of p+quarter turn).
  - S2: registered dual-read LUT.
  - S3: negate sin when q[1]; negate cos when q==1 or 2. Register the outputs.
- dout_valid is the active flag delayed 3 edges. The first sample (phase 0+ofs) appears after E3. When dout_valid=0, dout_sin and dout_cos are 0.
- Half-sample LUT offset makes mirror-by-inversion exact; no 2^LUT_AW entry needed; negation never overflows.

Test Plan:
- Defaults, mode 0, ftw=2^30, ofs=0, start -> from E3 dout_sin 25,32767,-25,-32767 repeating; dout_cos 32767,-25,-32767,25.
- Mode 0, ftw=2^30, ofs=2^30 -> dout_sin sequence equals the previous cos sequence; stop mid-run -> busy low next edge, exactly 3 trailing valid samples, then outputs 0.
- Mode 1, ftw=0, rate=1000, len=4 -> phases 0,0,1000,3000 feed LUT. busy high 4 cycles, sweep_done single pulse with busy falling, exactly 4 valid samples.
- Mode 3, ftw=0, rate=10, len=3 -> ftw trace 0,10,20,30,20,10,0,10... Sweep_done pulses every 6 cycles, only on up-leg end.
- cfg_valid while busy -> cfg_ready=0, shadow unchanged. Simultaneous start+stop in IDLE -> stays IDLE. cfg_len=0 -> behaves as len=1 (mode 1: one sample, one done pulse).
- Assert sys_rst during mode 2 sweep -> all outputs 0 asynchronously, cfg_ready=1. Start after release -> sequence restarts from phase 0.
